// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA command queue: address widths,
// transfer direction encodings, the queued command record and FSM states.
package dma_pkg;

  localparam int SIZE      = 16;   // shared-memory word pointer width
  localparam int PROCSIZE  = 12;   // processor-memory address / word-count width
  localparam int WORD_SIZE = 32;   // bits per transferred word
  localparam int PAGE_SIZE = 256;  // words per shared-memory page

  localparam logic READ  = 1'b0;   // shared memory -> processor memory
  localparam logic WRITE = 1'b1;   // processor memory -> shared memory

  typedef struct packed {
    logic                action;
    logic [SIZE-1:0]     ptr;
    logic [PROCSIZE-1:0] copy_start;
    logic [PROCSIZE-1:0] copy_length;
  } dma_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    ERROR
  } dma_state_t;

  // A zero-length command completes without involving the DMA engine.
  function automatic logic is_empty_cmd(input dma_cmd_t c);
    return c.copy_length == '0;
  endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Command FIFO for the DMA queue. The head entry stays in place until the
// controller pops it, so an in-flight command still counts toward the level.
// Pointers are log2(DEPTH) bits wide and wrap naturally (DEPTH is a power of two).
module dma_cmd_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  dma_cmd_t                 data_i,
  output dma_cmd_t                 head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;
  dma_cmd_t      mem_q [DEPTH];

  // Next-state for pointers and occupancy; a push into a full FIFO is dropped
  // even when a pop happens on the same edge.
  always_comb begin
    push_ok = push_i && (level_q != LW'(DEPTH));
    pop_ok  = pop_i && (level_q != '0);
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state: cleared by the queue reset, otherwise follows next-state.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Entry storage carries no reset; stale contents are never read while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/dma_cmd_queue.sv
// DMA command queue: buffers processor commands and hands them one at a time
// to a DMA engine using a toggle handshake (trigger out, ack back). A command
// leaves the FIFO only when its ack toggle is seen; a missing ack within
// TIMEOUT cycles latches a sticky error until the next start.
module dma_cmd_queue
  import dma_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clock,
  input  logic                   start,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_action,
  input  logic [SIZE-1:0]        cmd_ptr,
  input  logic [PROCSIZE-1:0]    cmd_copy_start,
  input  logic [PROCSIZE-1:0]    cmd_copy_length,
  output logic                   trigger,
  input  logic                   ack,
  output logic                   action,
  output logic [SIZE-1:0]        ptr,
  output logic [PROCSIZE-1:0]    copy_start,
  output logic [PROCSIZE-1:0]    copy_length,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  dma_state_t    state_q;
  dma_cmd_t      cmd_q;
  logic          trigger_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          last_ack_q;
  logic [CW-1:0] cnt_q;

  dma_cmd_t      in_cmd;
  dma_cmd_t      head;
  logic [LW-1:0] fifo_level;
  logic          has_head;
  logic          ack_seen;
  logic          push;
  logic          pop;

  dma_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .clr_i   (start),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_cmd),
    .head_o  (head),
    .level_o (fifo_level)
  );

  // Handshake decode; cmd_ready looks only at registered state so the
  // processor side never sees a combinational path from ack or cmd_valid.
  always_comb begin
    in_cmd.action      = cmd_action;
    in_cmd.ptr         = cmd_ptr;
    in_cmd.copy_start  = cmd_copy_start;
    in_cmd.copy_length = cmd_copy_length;
    cmd_ready          = (fifo_level != LW'(DEPTH)) && (state_q != ERROR);
    push               = cmd_valid && cmd_ready;
    has_head           = fifo_level != '0;
    ack_seen           = ack != last_ack_q;
    pop                = 1'b0;
    if (!start) begin
      case (state_q)
        IDLE:     pop = has_head && is_empty_cmd(head);
        WAIT_ACK: pop = ack_seen;
        default:  pop = 1'b0;
      endcase
    end
  end

  // Issue/acknowledge FSM with registered outputs; start overrides everything
  // and resynchronises last_ack to the current ack level.
  always_ff @(posedge clock) begin
    if (start) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      trigger_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      last_ack_q <= ack;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Acks arriving here belong to nothing in flight; absorb them.
          last_ack_q <= ack;
          if (has_head) begin
            if (is_empty_cmd(head)) begin
              done_q <= 1'b1;
            end else begin
              cmd_q   <= head;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          last_ack_q <= ack;
          trigger_q  <= ~trigger_q;
          cnt_q      <= '0;
          busy_q     <= 1'b1;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_seen) begin
            last_ack_q <= ack;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // This edge is the TIMEOUT-th waiting cycle; the command stays queued.
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          // ERROR: frozen until start.
          state_q <= ERROR;
        end
      endcase
    end
  end

  assign trigger     = trigger_q;
  assign action      = cmd_q.action;
  assign ptr         = cmd_q.ptr;
  assign copy_start  = cmd_q.copy_start;
  assign copy_length = cmd_q.copy_length;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign level       = fifo_level;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Scoreboard bench for dma_cmd_queue: accepted commands are queued in an
// in-order model; a negedge monitor matches every trigger toggle and done
// pulse against the model and tracks level, busy, ready and error state.
module tb_dma_cmd_queue;
  import dma_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic                   clock = 1'b0;
  logic                   start;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_action;
  logic [SIZE-1:0]        cmd_ptr;
  logic [PROCSIZE-1:0]    cmd_copy_start;
  logic [PROCSIZE-1:0]    cmd_copy_length;
  logic                   trigger;
  logic                   ack;
  logic                   action;
  logic [SIZE-1:0]        ptr;
  logic [PROCSIZE-1:0]    copy_start;
  logic [PROCSIZE-1:0]    copy_length;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;
  logic [$clog2(DEPTH):0] level;

  dma_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_action(cmd_action), .cmd_ptr(cmd_ptr), .cmd_copy_start(cmd_copy_start),
    .cmd_copy_length(cmd_copy_length), .trigger(trigger), .ack(ack),
    .action(action), .ptr(ptr), .copy_start(copy_start), .copy_length(copy_length),
    .busy(busy), .done(done), .timeout_err(timeout_err), .level(level)
  );

  always #5 clock = ~clock;

  int       checks   = 0;
  int       failures = 0;
  dma_cmd_t exp_q[$];
  bit       issued   = 0;
  bit       exp_err  = 0;
  logic     prev_trig = 1'b0;
  int       trig_cnt = 0;
  int       done_cnt = 0;
  int       acked    = 0;
  bit       push_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic dma_cmd_t mk(input logic a, input int p, input int s, input int l);
    dma_cmd_t c;
    c.action      = a;
    c.ptr         = SIZE'(p);
    c.copy_start  = PROCSIZE'(s);
    c.copy_length = PROCSIZE'(l);
    return c;
  endfunction

  // Monitor: samples on the falling edge, consumes the model queue in order.
  always @(negedge clock) begin
    if (start) begin
      exp_q.delete();
      issued    = 0;
      prev_trig = 1'b0;
      chk("rst_level", level, 0);
      chk("rst_trigger", trigger, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_cmd", {action, ptr, copy_start, copy_length}, 0);
    end else begin
      if (trigger !== prev_trig) begin
        trig_cnt++;
        if (exp_q.size() == 0) chk("trig_unexpected", 1, 0);
        else begin
          chk("issue_len_nonzero", exp_q[0].copy_length != 0, 1);
          chk("issue_cmd", {action, ptr, copy_start, copy_length}, exp_q[0]);
          issued = 1;
        end
      end
      prev_trig = trigger;
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          if (exp_q[0].copy_length != 0) chk("done_after_issue", issued, 1);
          void'(exp_q.pop_front());
          issued = 0;
        end
      end
      chk("level", level, exp_q.size());
      chk("busy", busy, issued);
      chk("timeout_err", timeout_err, exp_err);
      chk("cmd_ready", cmd_ready, (exp_q.size() < DEPTH) && !exp_err);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input dma_cmd_t c, output bit acc);
    cmd_valid       = 1'b1;
    cmd_action      = c.action;
    cmd_ptr         = c.ptr;
    cmd_copy_start  = c.copy_start;
    cmd_copy_length = c.copy_length;
    acc             = cmd_ready;
    @(posedge clock);
    if (acc) exp_q.push_back(c);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    start     = 1'b1;
    cmd_valid = 1'b0;
    exp_err   = 0;
    @(posedge clock);
    tick();
    start = 1'b0;
    acked = trig_cnt;
  endtask

  // Acknowledge every issued command one cycle after its trigger until empty.
  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      if (trig_cnt > acked) begin
        ack = ~ack;
        acked++;
      end
      tick();
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    bit       acc;
    dma_cmd_t c;
    int       d0;
    int       t0;
    logic     tr;
    ack             = 1'b0;
    cmd_action      = 1'b0;
    cmd_ptr         = '0;
    cmd_copy_start  = '0;
    cmd_copy_length = '0;
    do_reset();

    // Single command: latency from push to trigger and from ack to done.
    c = mk(WRITE, 5, 2, 3);
    push(c, acc);
    chk("s1_acc", acc, 1);
    chk("s1_out_e0", {action, ptr, copy_start, copy_length}, 0);
    tick();
    chk("s1_out_e1", {action, ptr, copy_start, copy_length}, c);
    chk("s1_trig_e1", trigger, 0);
    tick();
    chk("s1_trig_e2", trigger, 1);
    repeat (4) tick();
    ack = ~ack;
    acked++;
    tick();
    chk("s1_done_e7", done, 1);
    chk("s1_level_e7", level, 0);

    // Fill: fifth push refused, one ack frees a slot.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(mk(1'(i), 10 + i, 20 + i, 1 + i), acc);
      chk("fill_accept", acc, i < 4);
    end
    chk("fill_level", level, 4);
    chk("fill_ready", cmd_ready, 0);
    ack = ~ack;
    acked++;
    tick();
    chk("fill_level_after_ack", level, 3);
    chk("fill_ready_after_ack", cmd_ready, 1);
    drain("fill_drain");

    // Zero length followed by a real command.
    do_reset();
    d0 = done_cnt;
    t0 = trig_cnt;
    push(mk(READ, 7, 1, 0), acc);
    push(mk(READ, 8, 3, 2), acc);
    chk("zl_first_done", done_cnt, d0 + 1);
    drain("zl_drain");
    chk("zl_trig_once", trig_cnt, t0 + 1);
    chk("zl_two_done", done_cnt, d0 + 2);

    // Timeout: no ack, error on the TIMEOUT-th waiting cycle.
    do_reset();
    t0 = trig_cnt;
    push(mk(WRITE, 100, 4, 4), acc);
    for (int i = 0; i < 20 && trig_cnt == t0; i++) tick();
    chk("to_issued", trig_cnt, t0 + 1);
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet", timeout_err, 0);
    @(posedge clock);
    exp_err = 1;
    tick();
    chk("to_err", timeout_err, 1);
    chk("to_ready", cmd_ready, 0);
    d0 = done_cnt;
    push(mk(READ, 1, 1, 1), acc);
    chk("to_push_ignored", acc, 0);
    ack = ~ack;
    repeat (3) tick();
    chk("to_ack_ignored", done_cnt, d0);
    do_reset();
    chk("to_cleared_err", timeout_err, 0);

    // Reset mid-flight with three queued, trigger currently low.
    push(mk(WRITE, 30, 5, 6), acc);
    drain("mf_first");
    push(mk(READ, 31, 6, 7), acc);
    push(mk(READ, 32, 7, 8), acc);
    push(mk(WRITE, 33, 8, 9), acc);
    chk("mf_level", level, 3);
    chk("mf_busy", busy, 1);
    tr = trigger;
    d0 = done_cnt;
    t0 = trig_cnt;
    do_reset();
    chk("mf_trig_unchanged", trigger, tr);
    chk("mf_level0", level, 0);
    ack = ~ack;
    repeat (5) tick();
    chk("mf_no_done", done_cnt, d0);
    chk("mf_no_trig", trig_cnt, t0);

    // Push and ack on the same edge at level 2.
    do_reset();
    push(mk(WRITE, 40, 1, 5), acc);
    push(mk(READ, 41, 2, 6), acc);
    tick();
    chk("sim_issued", trig_cnt, acked + 1);
    chk("sim_level_before", level, 2);
    ack = ~ack;
    acked++;
    push(mk(WRITE, 42, 3, 7), acc);
    chk("sim_acc", acc, 1);
    chk("sim_level", level, 2);
    chk("sim_done", done, 1);
    drain("sim_drain");

    // Randomized traffic with a randomly delayed DMA responder.
    do_reset();
    push_done = 0;
    fork
      begin
        dma_cmd_t rc;
        bit       racc;
        int       tries;
        for (int i = 0; i < 40; i++) begin
          rc = mk(1'($urandom_range(0, 1)), int'($urandom), int'($urandom),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4095)));
          repeat ($urandom_range(0, 2)) tick();
          tries = 0;
          do begin
            push(rc, racc);
            tries++;
          end while (!racc && tries < 100);
          if (!racc) chk("rand_push_accept", 0, 1);
        end
        push_done = 1;
      end
      begin
        for (int g = 0; g < 3000; g++) begin
          if (trig_cnt > acked) begin
            repeat ($urandom_range(0, 4)) tick();
            ack = ~ack;
            acked++;
            tick();
          end else if (push_done && exp_q.size() == 0) begin
            break;
          end else begin
            tick();
          end
        end
      end
    join
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_no_err", timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
